// File: rtl/branch_predictor_pkg.sv
// Shared constants and saturating-counter helpers for the branch predictor slice.
package bp_pkg;

  localparam int BP_MODE_STATIC  = 0;
  localparam int BP_MODE_BIMODAL = 1;
  localparam int BP_MODE_GSHARE  = 2;

  // Weakly not-taken: one below the taken threshold.
  function automatic int ctr_init(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  function automatic int sat_inc(input int v, input int ctr_w);
    int max_v;
    max_v = (1 << ctr_w) - 1;
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  function automatic int sat_dec(input int v);
    return (v <= 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup/train/perf bundle between IF/ID and the branch predictor.
interface bp_if #(
  parameter int XLEN   = 32,
  parameter int HIST_W = 6
);
  logic [XLEN-1:0]   if_pc_i;
  logic              pred_taken_o;
  logic [XLEN-1:0]   pred_target_o;
  logic [HIST_W-1:0] pred_hist_o;
  logic              upd_valid_i;
  logic [XLEN-1:0]   upd_pc_i;
  logic [HIST_W-1:0] upd_hist_i;
  logic              upd_taken_i;
  logic [XLEN-1:0]   upd_target_i;
  logic              upd_mispredict_i;
  logic [31:0]       branch_cnt_o;
  logic [31:0]       mispred_cnt_o;

  modport slave (
    input  if_pc_i, upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i, upd_target_i,
           upd_mispredict_i,
    output pred_taken_o, pred_target_o, pred_hist_o, branch_cnt_o, mispred_cnt_o
  );

  modport master (
    output if_pc_i, upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i, upd_target_i,
           upd_mispredict_i,
    input  pred_taken_o, pred_target_o, pred_hist_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predictor_counter_table.sv
// Direction table: async-reset array of saturating counters, comb read, sync RMW write.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0] o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);
  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] r_ctr [DEPTH];

  assign o_rd_ctr = r_ctr[i_rd_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_W'(ctr_init(CTR_W));
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= i_wr_taken ? CTR_W'(sat_inc(int'(r_ctr[i_wr_idx]), CTR_W))
                                     : CTR_W'(sat_dec(int'(r_ctr[i_wr_idx])));
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: counter BHT (bimodal or gshare index), tagged BTB,
// non-speculative global history and saturating performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int TAG_W  = 8,
  parameter int HIST_W = 6,
  parameter int MODE   = 1
) (
  input logic clk_i,
  input logic rst_i,
  bp_if.slave bus
);
  localparam int DEPTH   = 1 << IDX_W;
  localparam bit ENABLED = (MODE == BP_MODE_BIMODAL) || (MODE == BP_MODE_GSHARE);
  localparam bit GSHARE  = (MODE == BP_MODE_GSHARE);

  logic [HIST_W-1:0] r_ghr;
  logic [DEPTH-1:0]  r_btb_valid;
  logic [TAG_W-1:0]  r_btb_tag [DEPTH];
  logic [XLEN-1:0]   r_btb_tgt [DEPTH];
  logic [31:0]       r_branch_cnt;
  logic [31:0]       r_mispred_cnt;

  logic [IDX_W-1:0]  w_lk_pc_idx, w_upd_pc_idx;
  logic [IDX_W-1:0]  w_lk_ghr, w_upd_ghr;
  logic [IDX_W-1:0]  w_lk_bht_idx, w_upd_bht_idx;
  logic [TAG_W-1:0]  w_lk_tag, w_upd_tag;
  logic [CTR_W-1:0]  w_lk_ctr;
  logic              w_hit, w_pred, w_upd_en, w_unused;

  assign w_lk_pc_idx  = bus.if_pc_i[IDX_W+1:2];
  assign w_upd_pc_idx = bus.upd_pc_i[IDX_W+1:2];
  assign w_lk_tag     = bus.if_pc_i[IDX_W+2 +: TAG_W];
  assign w_upd_tag    = bus.upd_pc_i[IDX_W+2 +: TAG_W];

  // Training hashes with the history captured at lookup, not the live GHR.
  always_comb begin
    w_lk_ghr  = '0;
    w_upd_ghr = '0;
    if (GSHARE) begin
      w_lk_ghr[HIST_W-1:0]  = r_ghr;
      w_upd_ghr[HIST_W-1:0] = bus.upd_hist_i;
    end
  end

  assign w_lk_bht_idx  = w_lk_pc_idx ^ w_lk_ghr;
  assign w_upd_bht_idx = w_upd_pc_idx ^ w_upd_ghr;

  assign w_hit  = r_btb_valid[w_lk_pc_idx] && (r_btb_tag[w_lk_pc_idx] == w_lk_tag);
  assign w_pred = ENABLED && w_lk_ctr[CTR_W-1] && w_hit;

  assign bus.pred_taken_o  = w_pred;
  assign bus.pred_target_o = w_pred ? r_btb_tgt[w_lk_pc_idx] : '0;
  assign bus.pred_hist_o   = r_ghr;
  assign bus.branch_cnt_o  = r_branch_cnt;
  assign bus.mispred_cnt_o = r_mispred_cnt;

  assign w_upd_en = ENABLED && bus.upd_valid_i;

  bp_counter_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_bht (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_rd_idx   (w_lk_bht_idx),
    .o_rd_ctr   (w_lk_ctr),
    .i_wr_en    (w_upd_en),
    .i_wr_idx   (w_upd_bht_idx),
    .i_wr_taken (bus.upd_taken_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ghr       <= '0;
      r_btb_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_btb_tag[i] <= '0;
        r_btb_tgt[i] <= '0;
      end
    end else if (w_upd_en) begin
      r_ghr <= HIST_W'({r_ghr, bus.upd_taken_i});
      if (bus.upd_taken_i) begin
        r_btb_valid[w_upd_pc_idx] <= 1'b1;
        r_btb_tag[w_upd_pc_idx]   <= w_upd_tag;
        r_btb_tgt[w_upd_pc_idx]   <= bus.upd_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (bus.upd_valid_i) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (bus.upd_mispredict_i && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  // pc[1:0], PC bits above the tag and the low counter bits carry no information here.
  assign w_unused = ^{bus.if_pc_i, bus.upd_pc_i, bus.upd_hist_i, w_lk_ctr};

endmodule
